// File: rtl/bip_debug_interface.sv
// bip_debug_interface: host supervisor for the BIP core; gates execution, counts cycles,
// and streams captured PC/ACC/cycle count to the UART transmitter as six bytes.
module bip_debug_interface #(
    parameter logic [7:0] START_CMD = 8'h53,
    parameter int         PC_W      = 11,
    parameter int         DATA_W    = 16,
    parameter int         CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              tx_done,
    input  logic              finish_program,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] acc,
    output logic              BIP_enable,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, RUN, SEND, HALT} state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_inc;
    logic [47:0]      r_fields, w_fields;
    logic [2:0]       r_idx;
    logic             w_start, w_finish, w_ack, w_last;
    logic             w_en, w_txs, w_busy;
    logic [7:0]       w_txd;

    function automatic logic [7:0] sel_byte(input logic [2:0] i, input logic [47:0] f);
        return 8'(f >> (6'd40 - {i, 3'b000}));
    endfunction

    assign w_start   = r_state == IDLE && rx_done && rx_data == START_CMD;
    assign w_finish  = r_state == RUN && finish_program;
    // a tx_done seen while our own tx_start is still high belongs to no byte yet
    assign w_ack     = r_state == SEND && tx_done && !tx_start;
    assign w_last    = r_idx == 3'd5;
    assign w_cnt_inc = &r_cnt ? r_cnt : r_cnt + CNT_W'(1);
    assign w_fields  = {16'(pc), 16'(acc), 16'(w_cnt_inc)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_start)
            w_next = RUN;
        else if (w_finish)
            w_next = SEND;
        else if (w_ack && w_last)
            w_next = HALT;
    end

    always_comb begin
        w_en   = w_next == RUN;
        w_busy = w_next == RUN || w_next == SEND;
        w_txs  = w_finish || (w_ack && !w_last);
        w_txd  = w_finish ? w_fields[47:40] :
                 (w_ack && !w_last) ? sel_byte(r_idx + 3'd1, r_fields) : tx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            BIP_enable <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= 8'd0;
            busy       <= 1'b0;
            r_cnt      <= '0;
            r_fields   <= '0;
            r_idx      <= 3'd0;
        end else begin
            BIP_enable <= w_en;
            tx_start   <= w_txs;
            tx_data    <= w_txd;
            busy       <= w_busy;
            r_cnt      <= w_start ? '0 : (r_state == RUN) ? w_cnt_inc : r_cnt;
            if (w_finish)
                r_fields <= w_fields;
            r_idx      <= w_finish ? 3'd0 : w_ack ? r_idx + 3'd1 : r_idx;
        end
    end
endmodule

// File: tb/tb_bip_debug_interface.sv
// tb_bip_debug_interface: table, hand-written and random checks of the BIP supervisor,
// driving a default instance and a CNT_W=4 instance with identical stimulus.
module tb_bip_debug_interface;
    logic        clk = 1'b0, reset = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_done = 1'b0, tx_done = 1'b0, finish_program = 1'b0;
    logic [10:0] pc = 11'd0;
    logic [15:0] acc = 16'd0;
    logic        en_a, st_a, bu_a, en_b, st_b, bu_b;
    logic [7:0]  td_a, td_b;
    int          checks = 0, errors = 0;

    bip_debug_interface dut_a (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
        .finish_program(finish_program), .pc(pc), .acc(acc),
        .BIP_enable(en_a), .tx_start(st_a), .tx_data(td_a), .busy(bu_a));

    bip_debug_interface #(.CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
        .finish_program(finish_program), .pc(pc), .acc(acc),
        .BIP_enable(en_b), .tx_start(st_b), .tx_data(td_b), .busy(bu_b));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pre;
        logic [10:0] pc;
        logic [15:0] acc;
        int          edges;
        int          delay;
        logic [47:0] exp_a;
        logic [47:0] exp_b;
    } vec_t;

    // expected byte stream: PC, ACC, count (saturated to the counter width), MSB first
    function automatic logic [47:0] model(input logic [10:0] p, input logic [15:0] a,
                                          input int e, input int cw);
        int lim = (1 << cw) - 1;
        int c = e > lim ? lim : e;
        return {5'b0, p, a, 16'(c)};
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_done = 1'b0;
        tx_done = 1'b0;
        finish_program = 1'b0;
        #2;
        chk("reset_outputs", {en_a, st_a, bu_a, td_a, en_b, st_b, bu_b, td_b}, 48'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("idle_spurious_txdone", {en_a, st_a, bu_a, en_b, st_b, bu_b}, 48'd0);
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic start_and_run(input logic [7:0] pre, input logic [10:0] p,
                                 input logic [15:0] a, input int e);
        send_rx(pre);
        chk("no_enable_other_byte", {en_a, bu_a, en_b, bu_b}, 48'd0);
        send_rx(8'h53);
        chk("enable_after_start", {en_a, st_a, bu_a, en_b, st_b, bu_b}, 48'b101101);
        pc = p;
        acc = a;
        for (int i = 1; i <= e; i++) begin
            finish_program = i == e;
            tx_done = 1'($urandom_range(0, 1));
            rx_done = 1'($urandom_range(0, 1));
            rx_data = 8'h53;
            tick();
            tx_done = 1'b0;
            rx_done = 1'b0;
            if (i < e)
                chk("run_outputs", {en_a, st_a, bu_a, en_b, st_b, bu_b}, 48'b101101);
        end
        pc = 11'($urandom);
        acc = 16'($urandom);
        chk("finish_outputs", {en_a, st_a, bu_a, en_b, st_b, bu_b}, 48'b011011);
    endtask

    task automatic collect(input int n, input int d, inout logic [47:0] ga, inout logic [47:0] gb);
        for (int k = 0; k < n; k++) begin
            chk("tx_start_pulse", {st_a, st_b}, 48'b11);
            ga = {ga[39:0], td_a};
            gb = {gb[39:0], td_b};
            for (int j = 0; j < d; j++) begin
                rx_done = 1'($urandom_range(0, 1));
                rx_data = 8'h53;
                tick();
                rx_done = 1'b0;
                chk("tx_hold", {st_a, st_b, bu_a, bu_b, en_a, en_b, td_a, td_b},
                    {6'b001100, ga[7:0], gb[7:0]});
            end
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        chk("halt_outputs", {en_a, st_a, bu_a, en_b, st_b, bu_b, td_a, td_b},
            {6'b0, ga[7:0], gb[7:0]});
        repeat (3) begin
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        chk("halt_stays", {en_a, st_a, bu_a, en_b, st_b, bu_b, td_a, td_b},
            {6'b0, ga[7:0], gb[7:0]});
    endtask

    initial begin
        vec_t        vecs[5];
        logic [47:0] ga, gb;
        logic [10:0] rp;
        logic [15:0] ra;
        logic [7:0]  rpre;
        int          re;
        vecs[0] = '{8'h41, 11'h005, 16'h1234, 10, 1,  48'h0005_1234_000A, 48'h0005_1234_000A};
        vecs[1] = '{8'h00, 11'h7FF, 16'hFFFF, 1,  2,  48'h07FF_FFFF_0001, 48'h07FF_FFFF_0001};
        vecs[2] = '{8'h52, 11'h123, 16'h0000, 20, 50, 48'h0123_0000_0014, 48'h0123_0000_000F};
        vecs[3] = '{8'hFF, 11'h000, 16'h8001, 15, 1,  48'h0000_8001_000F, 48'h0000_8001_000F};
        vecs[4] = '{8'h54, 11'h400, 16'h00FF, 16, 3,  48'h0400_00FF_0010, 48'h0400_00FF_000F};
        for (int v = 0; v < 5; v++) begin
            do_reset();
            start_and_run(vecs[v].pre, vecs[v].pc, vecs[v].acc, vecs[v].edges);
            ga = '0;
            gb = '0;
            collect(6, vecs[v].delay, ga, gb);
            chk("vec_bytes_a", ga, vecs[v].exp_a);
            chk("vec_bytes_b", gb, vecs[v].exp_b);
        end

        // tx_done coincident with the tx_start pulse is not an acknowledge
        do_reset();
        start_and_run(8'h10, 11'h2AB, 16'hBEEF, 3);
        ga = {40'd0, td_a};
        gb = {40'd0, td_b};
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("coincident_ignored", {st_a, st_b, td_a, td_b}, {2'b00, ga[7:0], gb[7:0]});
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        collect(5, 2, ga, gb);
        chk("coincident_bytes_a", ga, 48'h02AB_BEEF_0003);
        chk("coincident_bytes_b", gb, 48'h02AB_BEEF_0003);

        // reset in the middle of SEND, then a clean restart
        do_reset();
        start_and_run(8'h00, 11'h155, 16'h5A5A, 7);
        for (int k = 0; k < 3; k++) begin
            tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        chk("mid_send_next_start", {st_a, bu_a, td_a}, {2'b11, 8'h5A});
        do_reset();
        start_and_run(8'h41, 11'h00F, 16'h0001, 3);
        ga = '0;
        gb = '0;
        collect(6, 1, ga, gb);
        chk("restart_bytes_a", ga, 48'h000F_0001_0003);
        chk("restart_bytes_b", gb, 48'h000F_0001_0003);

        for (int r = 0; r < 8; r++) begin
            rp = 11'($urandom);
            ra = 16'($urandom);
            re = $urandom_range(1, 40);
            rpre = 8'($urandom);
            if (rpre == 8'h53)
                rpre = 8'h00;
            do_reset();
            start_and_run(rpre, rp, ra, re);
            ga = '0;
            gb = '0;
            collect(6, $urandom_range(1, 4), ga, gb);
            chk("rand_bytes_a", ga, model(rp, ra, re, 16));
            chk("rand_bytes_b", gb, model(rp, ra, re, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
